// File: rtl/rfsoc_chan_loader_pkg.sv
// rtl/rfsoc_chan_loader_pkg.sv - shared constants and state type for the channel loader
//
// Purpose : default sizing constants and the loader FSM state encoding.
// Contents: DEFAULT_NUM_CHANNELS, DEFAULT_DATA_WIDTH, DEFAULT_LEN_WIDTH, load_state_t.
package rfsoc_config;

  localparam int DEFAULT_NUM_CHANNELS = 16;
  localparam int DEFAULT_DATA_WIDTH   = 256;
  localparam int DEFAULT_LEN_WIDTH    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } load_state_t;

endpackage

// File: rtl/rfsoc_chan_loader_if.sv
// rtl/rfsoc_chan_loader_if.sv - command and stream bundle for the channel loader
//
// Purpose : groups the load-command handshake, the input stream and the
//           per-channel output streams.
// Ports   : cmd_valid/cmd_ready/cmd_mask/cmd_len  - load command
//           s_axis_tdata/tvalid/tready             - input beat stream
//           m_axis_tdata/tvalid/tready             - per-channel outputs,
//                                                    channel i at [i*DATA_WIDTH +: DATA_WIDTH]
// Modports: master drives commands/input beats and output ready (environment),
//           slave is the loader itself.
interface rfsoc_chan_loader_if #(
  parameter int NUM_CHANNELS = rfsoc_config::DEFAULT_NUM_CHANNELS,
  parameter int DATA_WIDTH   = rfsoc_config::DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH    = rfsoc_config::DEFAULT_LEN_WIDTH
);

  logic                               cmd_valid;
  logic                               cmd_ready;
  logic [NUM_CHANNELS-1:0]            cmd_mask;
  logic [LEN_WIDTH-1:0]               cmd_len;

  logic [DATA_WIDTH-1:0]              s_axis_tdata;
  logic                               s_axis_tvalid;
  logic                               s_axis_tready;

  logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_axis_tdata;
  logic [NUM_CHANNELS-1:0]            m_axis_tvalid;
  logic [NUM_CHANNELS-1:0]            m_axis_tready;

  modport master (
    output cmd_valid, cmd_mask, cmd_len,
    input  cmd_ready,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready
  );

  modport slave (
    input  cmd_valid, cmd_mask, cmd_len,
    output cmd_ready,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready
  );

endinterface

// File: rtl/rfsoc_chan_loader_axis_fork_reg.sv
// rtl/rfsoc_chan_loader_axis_fork_reg.sv - one-entry register forking a beat to many channels
//
// Purpose : holds one beat and a pending bit per destination channel. Each
//           channel retires its pending bit on its own handshake; the entry
//           is free once every pending bit has retired.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           flush             - drop the held entry
//           wr_en/wr_data/wr_mask - load a beat for the channels in wr_mask
//           wr_ready          - entry is empty or fully retiring this cycle
//           empty             - no pending bits held
//           out_data/out_valid/out_ready - replicated output streams
module axis_fork_reg #(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               wr_en,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [NUM_CHANNELS-1:0]            wr_mask,
  output logic                               wr_ready,
  output logic                               empty,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CHANNELS-1:0]            out_valid,
  input  logic [NUM_CHANNELS-1:0]            out_ready
);

  logic [NUM_CHANNELS-1:0] pending_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [NUM_CHANNELS-1:0] pending_left;

  // Bits still owed after this cycle's handshakes.
  assign pending_left = pending_q & ~out_ready;
  assign wr_ready     = (pending_left == '0);
  assign empty        = (pending_q == '0);

  // Valid comes straight from the register, never from ready.
  assign out_valid = pending_q;
  assign out_data  = {NUM_CHANNELS{data_q}};

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      data_q    <= '0;
    end else if (flush) begin
      pending_q <= '0;
    end else if (wr_en) begin
      data_q    <= wr_data;
      pending_q <= wr_mask;
    end else begin
      pending_q <= pending_left;
    end
  end

endmodule

// File: rtl/rfsoc_chan_loader.sv
// rtl/rfsoc_chan_loader.sv - loads a counted burst of beats into selected DAC channels
//
// Purpose : accepts a load command (channel mask, beat count), forwards that
//           many input beats to every selected channel through a one-entry
//           fork register, then reports completion and marks channels loaded.
// Ports   : pl_clk, rst   - clock, synchronous active-high reset
//           bus           - command, input stream and channel streams
//           abort         - cancel the load in progress
//           done, err     - one-cycle completion / rejection-or-abort pulses
//           loaded        - sticky per-channel loaded flags
//           beat_count    - beats accepted in the current load
module rfsoc_chan_loader
  import rfsoc_config::*;
#(
  parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH    = DEFAULT_LEN_WIDTH
) (
  input  logic                    pl_clk,
  input  logic                    rst,
  rfsoc_chan_loader_if.slave      bus,
  input  logic                    abort,
  output logic                    done,
  output logic                    err,
  output logic [NUM_CHANNELS-1:0] loaded,
  output logic [LEN_WIDTH-1:0]    beat_count
);

  load_state_t             state_q, state_d;
  logic [NUM_CHANNELS-1:0] mask_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic                    err_q, err_d;
  logic                    drain_done;
  logic                    cmd_accept, cmd_take;
  logic                    beat_accept, last_beat;
  logic                    fork_ready, fork_empty, fork_flush;

  assign bus.cmd_ready = !rst && (state_q == ST_IDLE) && !abort;
  assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;
  assign cmd_take      = cmd_accept && (bus.cmd_mask != '0);

  // beat_count < len_q keeps beat_count+1 from ever wrapping.
  assign bus.s_axis_tready = !rst && !abort && (state_q == ST_LOAD) &&
                             (beat_count < len_q) && fork_ready;
  assign beat_accept = bus.s_axis_tvalid && bus.s_axis_tready;
  assign last_beat   = beat_accept && ((beat_count + LEN_WIDTH'(1)) == len_q);

  assign fork_flush = abort && (state_q != ST_IDLE);

  axis_fork_reg #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_fork (
    .clk       (pl_clk),
    .rst       (rst),
    .flush     (fork_flush),
    .wr_en     (beat_accept),
    .wr_data   (bus.s_axis_tdata),
    .wr_mask   (mask_q),
    .wr_ready  (fork_ready),
    .empty     (fork_empty),
    .out_data  (bus.m_axis_tdata),
    .out_valid (bus.m_axis_tvalid),
    .out_ready (bus.m_axis_tready)
  );

  always_ff @(posedge pl_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Abort is tested ahead of completion so it wins over a same-cycle done.
  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          if (bus.cmd_mask == '0)      err_d   = 1'b1;
          else if (bus.cmd_len == '0)  state_d = ST_DRAIN;
          else                         state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (last_beat) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (fork_empty) begin
          drain_done = !rst;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done = drain_done;
  assign err  = err_q;

  always_ff @(posedge pl_clk) begin
    if (rst) begin
      mask_q     <= '0;
      len_q      <= '0;
      beat_count <= '0;
      loaded     <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (cmd_take) begin
        mask_q     <= bus.cmd_mask;
        len_q      <= bus.cmd_len;
        beat_count <= '0;
        loaded     <= loaded & ~bus.cmd_mask;
      end else begin
        if (beat_accept) beat_count <= beat_count + LEN_WIDTH'(1);
        if (drain_done)  loaded     <= loaded | mask_q;
      end
    end
  end

endmodule
